// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: sequential RV32I/M execute-stage ALU.
//   Base ops (add..and) and M-extension special cases complete in one cycle;
//   mul*/div*/rem* iterate one bit per cycle on operand magnitudes, with the
//   sign applied when the last step retires. Valid/ready on both sides.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid/ready  operand handshake; op, data1, data2 captured on accept
//   kill            synchronous abort of the in-flight op (wins over accept)
//   out_valid/ready result handshake; res held stable until consumed
module alu_seq_muldiv #(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINV     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW:0]    CNT_INIT = (SHW+1)'(XLEN);
  localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [SHW:0]    count;
  logic [XLEN-1:0] hi, lo, opa;  // mul: product hi/lo + multiplicand; div: rem/quot + divisor
  logic            neg;          // negate the final result
  logic            sel;          // mul: return high half; div: return remainder

  function automatic logic [XLEN-1:0] alu_base(input logic [7:0] o,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [SHW-1:0] sh;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (o)
      8'h01:   return a + b;
      8'h02:   return a - b;
      8'h03:   return a << sh;
      8'h04:   return {{(XLEN-1){1'b0}}, sa < sb};
      8'h05:   return {{(XLEN-1){1'b0}}, a < b};
      8'h06:   return a ^ b;
      8'h07:   return a >> sh;
      8'h08:   return sa >>> sh;
      8'h09:   return a | b;
      8'h0a:   return a & b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  // Decode of the presented op
  logic            is_mul, is_div, sgn1, sgn2, div_zero, div_ovf, accept, consume;
  logic [XLEN-1:0] mag1, mag2, quick_res;

  always_comb begin
    is_mul   = MULDIV_EN && (op >= 8'h0b) && (op <= 8'h0e);
    is_div   = MULDIV_EN && (op >= 8'h0f) && (op <= 8'h12);
    sgn1     = ((op == 8'h0c) || (op == 8'h0d) || (op == 8'h0f) || (op == 8'h11)) && data1[XLEN-1];
    sgn2     = ((op == 8'h0c) || (op == 8'h0f) || (op == 8'h11)) && data2[XLEN-1];
    mag1     = cond_neg(sgn1, data1);
    mag2     = cond_neg(sgn2, data2);
    div_zero = is_div && (data2 == '0);
    div_ovf  = is_div && ((op == 8'h0f) || (op == 8'h11)) && (data1 == MINV) && (data2 == '1);
    quick_res = alu_base(op, data1, data2);
    if (div_zero)
      quick_res = ((op == 8'h0f) || (op == 8'h10)) ? '1 : data1;
    else if (div_ovf)
      quick_res = (op == 8'h0f) ? MINV : '0;
  end

  assign in_ready = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready & ~kill;
  assign consume  = out_valid & out_ready;

  // One iteration step of either engine, plus the signed final result
  logic [XLEN:0]     mul_sum, r_sh, diff;
  logic              ge;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, mul_res, div_res;
  logic [2*XLEN-1:0] prod_n, prod_f;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
    mul_hi_n = mul_sum[XLEN:1];
    mul_lo_n = {mul_sum[0], lo[XLEN-1:1]};
    prod_n   = {mul_hi_n, mul_lo_n};
    prod_f   = neg ? -prod_n : prod_n;
    mul_res  = sel ? prod_f[2*XLEN-1:XLEN] : prod_f[XLEN-1:0];
    // Restoring division: partial remainder stays below the divisor, so the
    // shifted value fits XLEN+1 bits and the trial difference fits XLEN bits.
    r_sh     = {hi, lo[XLEN-1]};
    diff     = r_sh - {1'b0, opa};
    ge       = (r_sh >= {1'b0, opa});
    div_hi_n = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    div_lo_n = {lo[XLEN-2:0], ge};
    div_res  = sel ? cond_neg(neg, div_hi_n) : cond_neg(neg, div_lo_n);
  end

  // Control and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      out_valid <= 1'b0;
      res       <= '0;
      hi        <= '0;
      lo        <= '0;
      opa       <= '0;
      neg       <= 1'b0;
      sel       <= 1'b0;
    end else if (kill) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        state     <= MUL;
        count     <= CNT_INIT;
        out_valid <= 1'b0;
        hi        <= '0;
        lo        <= mag2;
        opa       <= mag1;
        neg       <= sgn1 ^ sgn2;
        sel       <= (op != 8'h0b);
      end else if (is_div && !div_zero && !div_ovf) begin
        state     <= DIV;
        count     <= CNT_INIT;
        out_valid <= 1'b0;
        hi        <= '0;
        lo        <= mag1;
        opa       <= mag2;
        sel       <= (op == 8'h11) || (op == 8'h12);
        neg       <= ((op == 8'h11) || (op == 8'h12)) ? sgn1 : (sgn1 ^ sgn2);
      end else begin
        state     <= DONE;
        out_valid <= 1'b1;
        res       <= quick_res;
      end
    end else begin
      case (state)
        MUL: begin
          hi    <= mul_hi_n;
          lo    <= mul_lo_n;
          count <= count - 1'b1;
          if (count == CNT_ONE) begin
            state     <= DONE;
            out_valid <= 1'b1;
            res       <= mul_res;
          end
        end
        DIV: begin
          hi    <= div_hi_n;
          lo    <= div_lo_n;
          count <= count - 1'b1;
          if (count == CNT_ONE) begin
            state     <= DONE;
            out_valid <= 1'b1;
            res       <= div_res;
          end
        end
        DONE: begin
          if (consume) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
module tb_alu_seq_muldiv;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  op = 8'h00;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  alu_seq_muldiv #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data1(data1), .data2(data2), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .res(res)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op with out_ready=1, wait (bounded) for its result.
  // lat counts edges from the accept edge (=1) to the edge raising out_valid.
  task automatic do_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat);
    op = o; data1 = a; data2 = b; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    r = res;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res got %h want 00000000", res); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_base();
    logic [7:0]  t_op [11] = '{8'h01, 8'h08, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h06, 8'h09, 8'h0a, 8'h20};
    logic [31:0] t_a  [11] = '{32'h7fffffff, 32'h80000000, 32'h3, 32'h1, 32'hffffffff, 32'hffffffff,
                               32'h80000000, 32'hf0f0, 32'hf0, 32'hf0, 32'h1};
    logic [31:0] t_b  [11] = '{32'h1, 32'd36, 32'h5, 32'h21, 32'h1, 32'h1, 32'h21, 32'hff00, 32'h0f, 32'h3c, 32'h1};
    logic [31:0] t_e  [11] = '{32'h80000000, 32'hf8000000, 32'hfffffffe, 32'h2, 32'h1, 32'h0,
                               32'h40000000, 32'h0ff0, 32'hff, 32'h30, 32'h0};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 11; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], r, lat);
      checks++; if (r !== t_e[i]) begin errors++; $display("FAIL base_res op %h got %h want %h", t_op[i], r, t_e[i]); end
      checks++; if (lat != 1) begin errors++; $display("FAIL base_lat op %h got %0d want 1", t_op[i], lat); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  t_op [3] = '{8'h01, 8'h06, 8'h02};
    logic [31:0] t_a  [3] = '{32'd1, 32'd6, 32'd10};
    logic [31:0] t_b  [3] = '{32'd2, 32'd3, 32'd4};
    logic [31:0] t_e  [3] = '{32'd3, 32'd5, 32'd6};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = t_op[i]; data1 = t_a[i]; data2 = t_b[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready %0d got %b want 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || res !== t_e[i]) begin
        errors++; $display("FAIL b2b_res %0d got v=%b %h want v=1 %h", i, out_valid, res, t_e[i]); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_muldiv();
    logic [7:0]  t_op [14] = '{8'h0c, 8'h0e, 8'h0b, 8'h0d, 8'h0f, 8'h11, 8'h10, 8'h0f, 8'h11, 8'h12,
                               8'h10, 8'h12, 8'h0f, 8'h11};
    logic [31:0] t_a  [14] = '{32'hffffffff, 32'hffffffff, 32'd7, 32'hffffffff, 32'hfffffff9, 32'hfffffff9,
                               32'd5, 32'h80000000, 32'h80000000, 32'd7, 32'd100, 32'd100, 32'd100, 32'hffffff9c};
    logic [31:0] t_b  [14] = '{32'hffffffff, 32'hffffffff, 32'hfffffffd, 32'd2, 32'd2, 32'd2,
                               32'd0, 32'hffffffff, 32'hffffffff, 32'd0, 32'd7, 32'd7, 32'hfffffff9, 32'd7};
    logic [31:0] t_e  [14] = '{32'h0, 32'hfffffffe, 32'hffffffeb, 32'hffffffff, 32'hfffffffd, 32'hffffffff,
                               32'hffffffff, 32'h80000000, 32'h0, 32'd7, 32'd14, 32'd2, 32'hfffffff2, 32'hfffffffe};
    int          t_l  [14] = '{33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33, 33, 33, 33};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 14; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], r, lat);
      checks++; if (r !== t_e[i]) begin errors++; $display("FAIL md_res #%0d op %h got %h want %h", i, t_op[i], r, t_e[i]); end
      checks++; if (lat != t_l[i]) begin errors++; $display("FAIL md_lat #%0d op %h got %0d want %0d", i, t_op[i], lat, t_l[i]); end
    end
    tick();
  endtask

  task automatic test_stall();
    op = 8'h01; data1 = 32'h10; data2 = 32'h20; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || res !== 32'h30) begin
      errors++; $display("FAIL stall_first got v=%b %h want v=1 00000030", out_valid, res); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || res !== 32'h30 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc %0d got v=%b r=%b %h want v=1 r=0 00000030", i, out_valid, in_ready, res); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_consume got %b want 0", out_valid); end
  endtask

  task automatic test_kill();
    logic [31:0] r;
    int lat;
    bit rose;
    op = 8'h0f; data1 = 32'd100; data2 = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) rose = 1'b1;
      tick();
    end
    checks++; if (rose) begin errors++; $display("FAIL kill_out_valid got 1 want 0"); end
    checks++; if (res !== 32'h30) begin errors++; $display("FAIL kill_res got %h want 00000030", res); end
    do_op(8'h01, 32'd2, 32'd3, r, lat);
    checks++; if (r !== 32'd5 || lat != 1) begin
      errors++; $display("FAIL kill_next_add got %h lat %0d want 00000005 lat 1", r, lat); end
    // op presented together with kill must not be accepted
    op = 8'h01; data1 = 32'd9; data2 = 32'd9; in_valid = 1'b1; kill = 1'b1;
    tick();
    in_valid = 1'b0; kill = 1'b0;
    checks++; if (out_valid !== 1'b0 || res !== 32'd5) begin
      errors++; $display("FAIL kill_blocks_accept got v=%b %h want v=0 00000005", out_valid, res); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] r;
    int lat;
    op = 8'h0b; data1 = 32'd6; data2 = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || res !== 32'h0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid got v=%b r=%b %h want v=0 r=0 00000000", out_valid, in_ready, res); end
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_release got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
    do_op(8'h0b, 32'd6, 32'd7, r, lat);
    checks++; if (r !== 32'd42 || lat != 33) begin
      errors++; $display("FAIL rst_then_mul got %h lat %0d want 0000002a lat 33", r, lat); end
    tick();
  endtask

  initial begin
    test_reset();
    test_base();
    test_back_to_back();
    test_muldiv();
    test_stall();
    test_kill();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
